neuron_mac: RTL
===============

# neuron_mac

Streaming multiply-accumulate stage of one neuron. It sits directly upstream of the ReLU activation stage. It multiplies each incoming activation by its stored weight and accumulates NUM_INPUTS products with saturation. It then adds the bias and presents the 2*DATA_WIDTH-bit sum to the activation stage with a one-cycle valid pulse.

## Interface
- NUM_INPUTS, 784, activations (and weights) per vector; must be ≥ 2
- DATA_WIDTH, 16, signed width of activation, weight and activation-stage output
- WEIGHT_INT_WIDTH, 4, integer bits of weight format; passed through unchanged, no effect on MAC arithmetic
- AW, $clog2(NUM_INPUTS), weight address width (derived)
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  i_data is valid this cycle
- i_data  in  DATA_WIDTH  signed activation
- i_wen  in  1  weight write enable
- i_waddr  in  AW  weight write address
- i_wdata  in  DATA_WIDTH  signed weight
- i_bias  in  2*DATA_WIDTH  signed bias, already in product format; sampled at output stage
- o_sum  out  2*DATA_WIDTH  signed saturated sum + bias, feeds activation-stage i_addr
- o_valid  out  1  one-cycle pulse, o_sum updated

## Operation
- Weight RAM: NUM_INPUTS x DATA_WIDTH, synchronous read, read-first. Not reset; contents survive i_rst.
- Input counter in_cnt (0..NUM_INPUTS-1) advances on each i_valid and wraps to 0 after NUM_INPUTS-1. first = (in_cnt==0), last = (in_cnt==NUM_INPUTS-1).
- Gaps in i_valid are allowed anywhere; no backpressure.
- Stage 1, RAM read at address in_cnt: registers x_d = i_data, weight w_q, and flags v1/first1/last1.
- Stage 2: mul_r = signed(x_d) * signed(w_q), full 2*DATA_WIDTH, cannot overflow. Flags v2/first2/last2.
- Stage 3, when v2: acc <= sat((first2 ? 0 : acc) + mul_r). Flags v3/last3 = v2 & last2.
- Stage 4, when last3: o_sum <= sat(acc + i_bias), o_valid <= 1; otherwise o_valid <= 0 and o_sum holds.
- sat(): computed in 2*DATA_WIDTH+1 bits, then clamped to [0x8000_0000, 0x7FFF_FFFF] for DATA_WIDTH=16 (generally -2^(2DW-1) .. 2^(2DW-1)-1).
- Accumulator saturation is sticky only through clamping. Later products still add to the clamped value.
- Weight write and stream read on the same address in the same cycle: the read returns the old weight and the new weight takes effect for later reads.
- i_rst, including mid-vector: in_cnt=0, all pipeline flags 0, acc=0, o_sum=0, o_valid=0. The partial vector is discarded and the next i_valid is treated as element 0.

## Timing
- Reset values: o_sum=0, o_valid=0.
- Latency: o_valid is high in cycle T+4 when the last element is accepted at cycle T.
- Throughput: one element per cycle. Back-to-back vectors need no bubble.
- The first product of vector k+1 loads acc in the same edge that o_sum captures vector k. o_sum uses the pre-edge acc.
- o_valid is never high for two consecutive cycles unless NUM_INPUTS=1, which is disallowed.
- i_bias must be stable in cycle T+3 and is captured at the T+4 edge.
- Downstream ReLU adds one more registered cycle. End-to-end neuron latency is T+5.

## Test plan
Bench uses NUM_INPUTS=4 and DATA_WIDTH=16.
- Basic: weights {1,2,3,4}, inputs {1,1,1,1} on consecutive cycles, bias 0 -> o_sum=0x0000_000A, o_valid pulse exactly 4 cycles after last input, one cycle wide.
- Bias/negative: same weights, inputs {1,1,1,1}, bias -20 -> o_sum=0xFFFF_FFF6. Then inputs {-1,-1,-1,-1}, bias 0 -> 0xFFFF_FFF6.
- Saturation: all weights 0x7FFF, inputs 0x7FFF -> 0x7FFF_FFFF. All weights 0x8000, inputs 0x7FFF -> 0x8000_0000. Bias +1 on a negative-saturated sum -> 0x8000_0001.
- Streaming: two vectors back-to-back, then a third with random 1-3 cycle i_valid gaps -> three correct sums, pulses at T+4 of each last element, no spurious pulses.
- Reset mid-vector: after 2 of 4 inputs, pulse i_rst asynchronously between edges -> o_sum=0 and o_valid=0 immediately. Next full vector {1,1,1,1} with weights {1,2,3,4} -> 0x0000_000A, weights retained.
- Weight collision: write weight[1]=100 in the same cycle element 1 is read -> that vector uses the old weight. The next vector uses 100.

Source files
------------

// File: rtl/neuron_mac.sv
// Streaming MAC stage of one neuron: weight RAM, 4-stage multiply/accumulate pipeline
// with saturating accumulate and bias add, one-cycle o_valid pulse per NUM_INPUTS vector.

module neuron_mac_wram #(
  parameter int N  = 784,
  parameter int DW = 16,
  parameter int AW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_wen,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  localparam logic [AW:0] DEPTH = (AW+1)'(N);

  logic [DW-1:0] mem [N];

  // Read-first: a same-address write lands after the old word is captured.
  always_ff @(posedge i_clk) begin
    if (i_wen && ({1'b0, i_waddr} < DEPTH)) mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end
endmodule

module neuron_mac #(
  parameter int NUM_INPUTS       = 784,
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_INT_WIDTH = 4,
  parameter int AW               = $clog2(NUM_INPUTS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_wen,
  input  logic [AW-1:0]               i_waddr,
  input  logic [DATA_WIDTH-1:0]       i_wdata,
  input  logic [2*DATA_WIDTH-1:0]     i_bias,
  output logic [2*DATA_WIDTH-1:0]     o_sum,
  output logic                        o_valid
);
  localparam int          PW   = 2*DATA_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(NUM_INPUTS-1);

  // Weight format is fixed-point but only matters downstream; just sanity-check it here.
  if (NUM_INPUTS < 2 || WEIGHT_INT_WIDTH > DATA_WIDTH) begin : g_bad_params
    $error("neuron_mac: NUM_INPUTS must be >= 2 and WEIGHT_INT_WIDTH <= DATA_WIDTH");
  end

  typedef struct packed {
    logic first;
    logic last;
  } tag_t;

  function automatic logic [PW-1:0] sat(input logic [PW:0] v);
    if (v[PW] != v[PW-1]) sat = v[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    else                  sat = v[PW-1:0];
  endfunction

  logic [AW-1:0]               in_cnt;
  logic [3:1]                  vld_pipe;
  tag_t                        tag1, tag2;
  logic                        last3;
  logic signed [DATA_WIDTH-1:0] x_d, w_q;
  logic signed [PW-1:0]        mul_r;
  logic [PW-1:0]               acc;
  logic [PW-1:0]               acc_base;
  logic [PW:0]                 acc_nxt, out_nxt;

  neuron_mac_wram #(.N(NUM_INPUTS), .DW(DATA_WIDTH), .AW(AW)) u_wram (
    .i_clk   (i_clk),
    .i_wen   (i_wen),
    .i_waddr (i_waddr),
    .i_wdata (i_wdata),
    .i_raddr (in_cnt),
    .o_rdata (w_q)
  );

  always_comb begin
    acc_base = tag2.first ? '0 : acc;
    acc_nxt  = {acc_base[PW-1], acc_base} + {mul_r[PW-1], mul_r};
    out_nxt  = {acc[PW-1], acc} + {i_bias[PW-1], i_bias};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_cnt   <= '0;
      vld_pipe <= '0;
      tag1     <= '0;
      tag2     <= '0;
      last3    <= 1'b0;
      x_d      <= '0;
      mul_r    <= '0;
      acc      <= '0;
      o_sum    <= '0;
      o_valid  <= 1'b0;
    end else begin
      if (i_valid) in_cnt <= (in_cnt == LAST) ? '0 : in_cnt + 1'b1;
      vld_pipe <= {vld_pipe[2:1], i_valid};
      // stage 1: RAM read of w_q runs in parallel at address in_cnt
      x_d  <= i_data;
      tag1 <= '{first: (in_cnt == '0), last: (in_cnt == LAST)};
      // stage 2
      mul_r <= x_d * w_q;
      tag2  <= tag1;
      // stage 3: first product of a vector reloads acc, discarding the previous total
      if (vld_pipe[2]) acc <= sat(acc_nxt);
      last3 <= vld_pipe[2] & tag2.last;
      // stage 4: uses pre-edge acc, so it coexists with the next vector's first load
      if (vld_pipe[3] && last3) begin
        o_sum   <= sat(out_nxt);
        o_valid <= 1'b1;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end
endmodule
